// File: rtl/alu32_core.sv
// alu32_core: 32-bit registered ALU covering add, subtract, equal, not-equal,
//             signed less-or-equal, signed greater-than and three shift kinds.
// Latency:    1 cycle. Operands are sampled on the rising clk edge with
//             in_valid=1, and out_valid/ans1/ans2/Z/N update on that same edge.
// Backpressure: none. Every valid input produces one result. With in_valid=0
//             the result registers hold and out_valid drops.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every output
//   in_valid   a/b/opCode/c are valid this cycle
//   a, b       operands; b is also the full unsigned shift amount
//   opCode     6-bit operation select (see localparams)
//   c          carry-in for ADD, borrow-in for SUB; ignored otherwise
//   out_valid  ans1/ans2/Z/N hold a result that is new this cycle
//   ans1       result
//   ans2       carry-out (ADD) or borrow-out (SUB); 0 for other opcodes
//   Z, N       zero flag and sign flag of ans1
module alu32_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       opCode,
  input  logic             c,
  output logic             out_valid,
  output logic [WIDTH-1:0] ans1,
  output logic             ans2,
  output logic             Z,
  output logic             N
);

  // Opcode map. Any code not listed here is illegal and yields a zero result.
  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_EQ  = 6'b000010;
  localparam logic [5:0] OP_NE  = 6'b000011;
  localparam logic [5:0] OP_LE  = 6'b000100;
  localparam logic [5:0] OP_GT  = 6'b000101;
  localparam logic [5:0] OP_LLS = 6'b000110;
  localparam logic [5:0] OP_LRS = 6'b000111;
  localparam logic [5:0] OP_ARS = 6'b110001;

  // Number of shift-amount bits that select a position inside the word.
  localparam int SHW = $clog2(WIDTH);

  // ---------------------------------------------------------------------------
  // Adder / subtractor
  // ---------------------------------------------------------------------------
  // Both operate on zero-extended operands. For the sum, bit WIDTH is the carry.
  // For the difference, a result below zero wraps to a 33-bit two's-complement
  // value with bit WIDTH set. That bit is therefore the borrow-out, which is
  // equivalent to a < b + c.
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  assign w_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c};

  // ---------------------------------------------------------------------------
  // Comparator
  // ---------------------------------------------------------------------------
  logic w_eq;
  logic w_lt_s;
  logic w_le_s;

  assign w_eq   = (a == b);
  assign w_lt_s = ($signed(a) < $signed(b));
  assign w_le_s = w_lt_s | w_eq;

  // ---------------------------------------------------------------------------
  // Shifter
  // ---------------------------------------------------------------------------
  // The full 32-bit b is the shift amount. Any amount of WIDTH or more pushes
  // every original bit out of the word. Those cases are detected from the upper
  // bits of b, so the barrel shifter only sees the low SHW bits.
  logic             w_shift_big;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_lls;
  logic [WIDTH-1:0] w_lrs;
  logic [WIDTH-1:0] w_ars;
  logic [WIDTH-1:0] w_sign_fill;

  assign w_shift_big = |b[WIDTH-1:SHW];
  assign w_shamt     = b[SHW-1:0];
  assign w_sign_fill = {WIDTH{a[WIDTH-1]}};

  assign w_lls = w_shift_big ? '0 : (a << w_shamt);
  assign w_lrs = w_shift_big ? '0 : (a >> w_shamt);
  assign w_ars = w_shift_big ? w_sign_fill : WIDTH'($signed(a) >>> w_shamt);

  // ---------------------------------------------------------------------------
  // Result select
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_res;
  logic             w_cout;

  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    unique case (opCode)
      OP_ADD: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_res  = w_diff[WIDTH-1:0];
        w_cout = w_diff[WIDTH];
      end
      OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, w_eq};
      OP_NE:   w_res = {{(WIDTH-1){1'b0}}, ~w_eq};
      OP_LE:   w_res = {{(WIDTH-1){1'b0}}, w_le_s};
      OP_GT:   w_res = {{(WIDTH-1){1'b0}}, ~w_le_s};
      OP_LLS:  w_res = w_lls;
      OP_LRS:  w_res = w_lrs;
      OP_ARS:  w_res = w_ars;
      default: begin
        // Illegal opcode: zero result, which drives Z=1 and N=0.
        w_res  = '0;
        w_cout = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  // The flags are computed from the value being registered into ans1. They
  // therefore always describe the registered result, including for compares.
  logic             r_out_valid;
  logic [WIDTH-1:0] r_ans1;
  logic             r_ans2;
  logic             r_z;
  logic             r_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_ans1      <= '0;
      r_ans2      <= 1'b0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_ans1 <= w_res;
        r_ans2 <= w_cout;
        r_z    <= (w_res == '0);
        r_n    <= w_res[WIDTH-1];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign ans1      = r_ans1;
  assign ans2      = r_ans2;
  assign Z         = r_z;
  assign N         = r_n;

endmodule

// File: tb/tb_alu32_core.sv
// tb_alu32_core: scoreboard bench for alu32_core.
// The driver drives inputs on the falling edge and pushes the expected outputs
// of the following rising edge. The monitor pops one entry per cycle and compares.
module tb_alu32_core;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [5:0]  opCode;
  logic        c;
  logic        out_valid;
  logic [31:0] ans1;
  logic        ans2;
  logic        Z;
  logic        N;

  alu32_core #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .opCode(opCode), .c(c), .out_valid(out_valid), .ans1(ans1),
    .ans2(ans2), .Z(Z), .N(N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        vld;
    logic [31:0] ans1;
    logic        ans2;
    logic        z;
    logic        n;
  } exp_t;

  exp_t sb_q[$];

  // Reference state: the outputs the ALU should currently be holding.
  logic [31:0] m_ans1;
  logic        m_ans2;
  logic        m_z;
  logic        m_n;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference, computed directly from the operation definitions.
  task automatic model(input logic [31:0] xa, input logic [31:0] xb,
                       input logic [5:0] op, input logic xc,
                       output logic [31:0] r, output logic cy);
    logic [63:0] s;
    r  = 32'h0;
    cy = 1'b0;
    case (op)
      6'b000000: begin
        s  = 64'(xa) + 64'(xb) + 64'(xc);
        r  = s[31:0];
        cy = s[32];
      end
      6'b000001: begin
        r  = xa - xb - 32'(xc);
        cy = (64'(xa) < 64'(xb) + 64'(xc));
      end
      6'b000010: r = (xa == xb) ? 32'd1 : 32'd0;
      6'b000011: r = (xa != xb) ? 32'd1 : 32'd0;
      6'b000100: r = ($signed(xa) <= $signed(xb)) ? 32'd1 : 32'd0;
      6'b000101: r = ($signed(xa) >  $signed(xb)) ? 32'd1 : 32'd0;
      6'b000110: r = (xb >= 32) ? 32'd0 : (xa << xb);
      6'b000111: r = (xb >= 32) ? 32'd0 : (xa >> xb);
      6'b110001: r = (xb >= 32) ? {32{xa[31]}} : 32'($signed(xa) >>> xb);
      default:   r = 32'd0;
    endcase
  endtask

  task automatic drive(input logic v, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [5:0] op, input logic xc);
    logic [31:0] r;
    logic        cy;
    exp_t        e;
    @(negedge clk);
    in_valid = v;
    a        = xa;
    b        = xb;
    opCode   = op;
    c        = xc;
    if (v) begin
      model(xa, xb, op, xc, r, cy);
      m_ans1 = r;
      m_ans2 = cy;
      m_z    = (r == 32'd0);
      m_n    = r[31];
    end
    e.vld  = v;
    e.ans1 = m_ans1;
    e.ans2 = m_ans2;
    e.z    = m_z;
    e.n    = m_n;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, $urandom, $urandom, 6'($urandom), 1'($urandom));
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, ".ans1"},      ans1,           32'd0);
    chk({nm, ".ans2"},      32'(ans2),      32'd0);
    chk({nm, ".Z"},         32'(Z),         32'd0);
    chk({nm, ".N"},         32'(N),         32'd0);
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_ans1 = 32'd0;
    m_ans2 = 1'b0;
    m_z    = 1'b0;
    m_n    = 1'b0;
  endtask

  // Monitor: one comparison set per rising edge, sampled 1ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) continue;
      if (sb_q.size() == 0) begin
        chk("idle.out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("out_valid", 32'(out_valid), 32'(e.vld));
        chk("ans1",      ans1,           e.ans1);
        chk("ans2",      32'(ans2),      32'(e.ans2));
        chk("Z",         32'(Z),         32'(e.z));
        chk("N",         32'(N),         32'(e.n));
      end
    end
  end

  // Watchdog: the bench must always terminate.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  logic [5:0] legal_ops [9] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011,
                                6'b000100, 6'b000101, 6'b000110, 6'b000111,
                                6'b110001};

  initial begin
    logic [31:0] ra, rb;
    logic [5:0]  rop;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 32'd0;
    b        = 32'd0;
    opCode   = 6'd0;
    c        = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // First operation after reset.
    drive(1, 32'h00010000, 32'd1, 6'b110001, 0);
    // ARS sign fill.
    drive(1, 32'h80000000, 32'd4,  6'b110001, 0);
    drive(1, 32'h80000000, 32'd40, 6'b110001, 0);
    drive(1, 32'h7FFFFFFF, 32'd31, 6'b110001, 0);
    // EQ / NE.
    drive(1, 32'h1234ABCD, 32'h1234ABCD, 6'b000010, 0);
    drive(1, 32'h1234ABCD, 32'h1234ABCD, 6'b000011, 0);
    drive(1, 32'd5, 32'd6, 6'b000010, 0);
    // ADD / SUB carries and borrows.
    drive(1, 32'hFFFFFFFF, 32'd0, 6'b000000, 1);
    drive(1, 32'd3, 32'd5, 6'b000001, 0);
    drive(1, 32'd5, 32'd5, 6'b000001, 0);
    drive(1, 32'd5, 32'd5, 6'b000001, 1);
    drive(1, 32'd0, 32'hFFFFFFFF, 6'b000001, 1);
    // Compare and shift corners.
    drive(1, 32'hFFFFFFFF, 32'd0, 6'b000100, 0);
    drive(1, 32'd0, 32'h80000000, 6'b000101, 0);
    drive(1, 32'd1, 32'd31, 6'b000110, 0);
    drive(1, 32'h80000000, 32'd31, 6'b000111, 0);
    drive(1, 32'hDEADBEEF, 32'd0, 6'b000110, 0);
    drive(1, 32'hDEADBEEF, 32'd32, 6'b000111, 0);
    drive(1, 32'hDEADBEEF, 32'h00010000, 6'b000110, 0);
    drive(1, 32'hDEADBEEF, 32'd0, 6'b110001, 0);
    drive(1, 32'h12345678, 32'h9, 6'b111111, 1);
    // Throughput, then hold.
    drive(1, 32'h7FFFFFFF, 32'd1, 6'b000000, 0);
    drive(1, 32'd9, 32'd9, 6'b000010, 0);
    drive(1, 32'hF0000000, 32'd2, 6'b110001, 0);
    idle();
    idle();

    // Reset mid-operation: the in-flight result is discarded.
    drive(1, 32'd100, 32'd23, 6'b000000, 0);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1 check_all_zero("async_reset");
    @(posedge clk);
    #1 check_all_zero("reset_hold");
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle();
    idle();
    drive(1, 32'd100, 32'd23, 6'b000001, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = $urandom_range(0, 40);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) rop = 6'($urandom);
      else                           rop = legal_ops[$urandom_range(0, 8)];
      drive(1'($urandom_range(0, 3) != 0), ra, rb, rop, 1'($urandom));
    end
    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
